feature_frame_loader: RTL and testbench

Upstream feeder for `hdc_sensor_fusion`. Accepts one quantised channel feature per handshake over a narrow stream and assembles full feature frames. Presents each complete frame on a wide `features_top` bus with a valid/ready handshake to the fusion core's `fin_valid` / `fin_ready`. Detects framing errors through a last-channel marker and drops malformed frames.

---
 rtl/feature_frame_loader_pkg.sv | 18 +
 rtl/feature_frame_loader_frame_buffer.sv | 50 +++++
 rtl/feature_frame_loader.sv | 123 ++++++++++++
 tb/tb_feature_frame_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/feature_frame_loader_pkg.sv
// Shared constants and buffer-state type for the feature frame loader.
// The double-buffer build is selected with FEATURE_LOADER_DBUF_EN (see feature_frame_loader.sv).
package feature_frame_loader_pkg;

  localparam int TOTAL_NUM_CHANNEL = 4;
  localparam int CHANNEL_WIDTH     = 2;

  typedef enum logic {
    BUF_FILL = 1'b0,
    BUF_FULL = 1'b1
  } buf_state_e;

  // A one-channel frame still needs a one-bit counter to stay a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_frame_loader_frame_buffer.sv
// One frame buffer: per-channel write port, FILL/FULL flag, cleared on the output handshake.
// Channel 0 is packed into the MSBs of data_o.
module frame_buffer
  import feature_frame_loader_pkg::*;
#(
  parameter int NUM_CHANNEL = TOTAL_NUM_CHANNEL,
  parameter int WIDTH       = CHANNEL_WIDTH,
  parameter int IDX_W       = idx_width(TOTAL_NUM_CHANNEL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         set_full_i,
  input  logic                         clr_full_i,
  output logic                         full_o,
  output logic [NUM_CHANNEL*WIDTH-1:0] data_o
);

  buf_state_e       state_q;
  logic [WIDTH-1:0] chan_q [NUM_CHANNEL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_FILL;
    end else if (set_full_i) begin
      state_q <= BUF_FULL;
    end else if (clr_full_i) begin
      state_q <= BUF_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNEL; i++) chan_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(i))) chan_q[i] <= wr_data_i;
      end
    end
  end

  assign full_o = (state_q == BUF_FULL);

  for (genvar gi = 0; gi < NUM_CHANNEL; gi++) begin : g_pack
    assign data_o[(NUM_CHANNEL-1-gi)*WIDTH +: WIDTH] = chan_q[gi];
  end

endmodule

// File: rtl/feature_frame_loader.sv
// Assembles per-channel feature beats into full frames and hands them to the fusion core.
// Define FEATURE_LOADER_DBUF_EN for ping-pong double buffering; otherwise a single buffer is used.
module feature_frame_loader
  import feature_frame_loader_pkg::*;
#(
  parameter int NUM_CHANNEL = TOTAL_NUM_CHANNEL,
  parameter int WIDTH       = CHANNEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_last,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic [NUM_CHANNEL*WIDTH-1:0] features_top,
  output logic                         fin_valid,
  input  logic                         fin_ready,
  output logic                         frame_err
);

  localparam int               IDX_W    = idx_width(NUM_CHANNEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNEL - 1);
`ifdef FEATURE_LOADER_DBUF_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  logic [IDX_W-1:0] chan_idx_q, chan_idx_d;
  logic             din_ready_q, din_ready_d;
  logic             frame_err_q, frame_err_d;

  logic accept, at_last_idx, frame_done, frame_bad, out_hs;
  logic [NBUF-1:0] wr_oh, rd_oh, full_vec, set_vec, clr_vec, full_next;
  logic [NUM_CHANNEL*WIDTH-1:0] buf_data [NBUF];
  logic [NUM_CHANNEL*WIDTH-1:0] mux_data;

  assign accept      = din_valid & din_ready_q;
  assign at_last_idx = (chan_idx_q == LAST_IDX);
  assign frame_done  = accept & din_last & at_last_idx;
  // Early last and missing last are the two ways din_last can disagree with the counter.
  assign frame_bad   = accept & (din_last ^ at_last_idx);

  assign fin_valid = |(full_vec & rd_oh);
  assign out_hs    = fin_valid & fin_ready;

  assign set_vec   = wr_oh & {NBUF{frame_done}};
  assign clr_vec   = rd_oh & {NBUF{out_hs}};
  assign full_next = set_vec | (full_vec & ~clr_vec);

`ifdef FEATURE_LOADER_DBUF_EN
  logic wr_sel_q, rd_sel_q;

  // Write and read pointers advance alternately, so frames leave in arrival order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      if (frame_done) wr_sel_q <= ~wr_sel_q;
      if (out_hs)     rd_sel_q <= ~rd_sel_q;
    end
  end

  assign wr_oh = {wr_sel_q, ~wr_sel_q};
  assign rd_oh = {rd_sel_q, ~rd_sel_q};
`else
  assign wr_oh = 1'b1;
  assign rd_oh = 1'b1;
`endif

  for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
    frame_buffer #(
      .NUM_CHANNEL (NUM_CHANNEL),
      .WIDTH       (WIDTH),
      .IDX_W       (IDX_W)
    ) u_frame_buffer (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (accept & wr_oh[gi]),
      .wr_idx_i   (chan_idx_q),
      .wr_data_i  (din),
      .set_full_i (set_vec[gi]),
      .clr_full_i (clr_vec[gi]),
      .full_o     (full_vec[gi]),
      .data_o     (buf_data[gi])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (rd_oh[i]) mux_data = mux_data | buf_data[i];
    end
  end

  assign features_top = mux_data;

  always_comb begin
    chan_idx_d = chan_idx_q;
    if (accept) begin
      chan_idx_d = (din_last || at_last_idx) ? '0 : chan_idx_q + IDX_W'(1);
    end
    din_ready_d = ~&full_next;
    frame_err_d = frame_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_idx_q  <= '0;
      din_ready_q <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      chan_idx_q  <= chan_idx_d;
      din_ready_q <= din_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign din_ready = din_ready_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_feature_frame_loader.sv
// Directed bench for feature_frame_loader (NUM_CHANNEL=4, WIDTH=2); honours FEATURE_LOADER_DBUF_EN.
module tb_feature_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = '0;
  logic       din_last = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] features_top;
  logic       fin_valid;
  logic       fin_ready = 1'b0;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  feature_frame_loader #(.NUM_CHANNEL(4), .WIDTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_last     (din_last),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .features_top (features_top),
    .fin_valid    (fin_valid),
    .fin_ready    (fin_ready),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] d, input logic last);
    check("din_ready_before_beat", {31'd0, din_ready}, 32'd1);
    din = d;
    din_last = last;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din_last = 1'b0;
    $display("beat din=%0d last=%0b -> fin_valid=%0b features_top=0x%02h frame_err=%0b",
             d, last, fin_valid, features_top, frame_err);
  endtask

  logic [7:0] b2b_exp [3];
  logic [1:0] b2b_beat [3][4];

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("rst_fin_valid", {31'd0, fin_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_features", {24'd0, features_top}, 32'd0);
    rst = 1'b0;
    tick();

    // Single frame, consumer ready
    fin_ready = 1'b1;
    beat(2'd3, 1'b0);
    beat(2'd2, 1'b0);
    beat(2'd1, 1'b0);
    check("single_no_early_valid", {31'd0, fin_valid}, 32'd0);
    beat(2'd0, 1'b1);
    check("single_fin_valid", {31'd0, fin_valid}, 32'd1);
    check("single_features", {24'd0, features_top}, 32'hE4);
    check("single_frame_err", {31'd0, frame_err}, 32'd0);
`ifdef FEATURE_LOADER_DBUF_EN
    check("single_din_ready", {31'd0, din_ready}, 32'd1);
`else
    check("single_din_ready", {31'd0, din_ready}, 32'd0);
`endif
    tick();
    check("single_valid_drop", {31'd0, fin_valid}, 32'd0);
    check("single_ready_back", {31'd0, din_ready}, 32'd1);

    // Backpressure
    fin_ready = 1'b0;
    beat(2'd1, 1'b0);
    beat(2'd2, 1'b0);
    beat(2'd3, 1'b0);
    beat(2'd0, 1'b1);
    check("bp_fin_valid", {31'd0, fin_valid}, 32'd1);
    check("bp_features", {24'd0, features_top}, 32'h6C);
`ifdef FEATURE_LOADER_DBUF_EN
    beat(2'd0, 1'b0);
    beat(2'd1, 1'b0);
    beat(2'd2, 1'b0);
    beat(2'd3, 1'b1);
    check("bp_second_loaded_ready", {31'd0, din_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_valid", {31'd0, fin_valid}, 32'd1);
      check("bp_hold_features", {24'd0, features_top}, 32'h6C);
      check("bp_hold_ready", {31'd0, din_ready}, 32'd0);
      tick();
    end
    fin_ready = 1'b1;
    tick();
    check("bp_second_valid", {31'd0, fin_valid}, 32'd1);
    check("bp_second_features", {24'd0, features_top}, 32'h1B);
    check("bp_ready_release", {31'd0, din_ready}, 32'd1);
    tick();
    check("bp_done_valid", {31'd0, fin_valid}, 32'd0);
`else
    check("bp_ready_low", {31'd0, din_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", {31'd0, fin_valid}, 32'd1);
      check("bp_hold_features", {24'd0, features_top}, 32'h6C);
      check("bp_hold_ready", {31'd0, din_ready}, 32'd0);
      tick();
    end
    fin_ready = 1'b1;
    tick();
    check("bp_done_valid", {31'd0, fin_valid}, 32'd0);
    check("bp_ready_release", {31'd0, din_ready}, 32'd1);
`endif

    // Early last on beat 2
    beat(2'd2, 1'b0);
    check("early_no_err_first", {31'd0, frame_err}, 32'd0);
    beat(2'd1, 1'b1);
    check("early_frame_err", {31'd0, frame_err}, 32'd1);
    check("early_no_valid", {31'd0, fin_valid}, 32'd0);
    tick();
    check("early_err_one_cycle", {31'd0, frame_err}, 32'd0);
    check("early_still_no_valid", {31'd0, fin_valid}, 32'd0);
    beat(2'd0, 1'b0);
    beat(2'd3, 1'b0);
    beat(2'd0, 1'b0);
    beat(2'd3, 1'b1);
    check("early_next_valid", {31'd0, fin_valid}, 32'd1);
    check("early_next_features", {24'd0, features_top}, 32'h33);
    tick();
    check("early_next_consumed", {31'd0, fin_valid}, 32'd0);

    // Missing last
    beat(2'd1, 1'b0);
    beat(2'd1, 1'b0);
    beat(2'd1, 1'b0);
    beat(2'd1, 1'b0);
    check("missing_frame_err", {31'd0, frame_err}, 32'd1);
    check("missing_no_valid", {31'd0, fin_valid}, 32'd0);
    tick();
    check("missing_err_one_cycle", {31'd0, frame_err}, 32'd0);
    beat(2'd2, 1'b0);
    beat(2'd2, 1'b0);
    beat(2'd2, 1'b0);
    beat(2'd2, 1'b1);
    check("missing_next_valid", {31'd0, fin_valid}, 32'd1);
    check("missing_next_features", {24'd0, features_top}, 32'hAA);
    check("missing_next_no_err", {31'd0, frame_err}, 32'd0);
    tick();

`ifdef FEATURE_LOADER_DBUF_EN
    // Back-to-back frames, no stall expected
    b2b_exp[0] = 8'hE4;
    b2b_exp[1] = 8'h1B;
    b2b_exp[2] = 8'h6C;
    b2b_beat[0] = '{2'd3, 2'd2, 2'd1, 2'd0};
    b2b_beat[1] = '{2'd0, 2'd1, 2'd2, 2'd3};
    b2b_beat[2] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        beat(b2b_beat[f][k], (k == 3));
        if (k == 3) begin
          check("b2b_valid", {31'd0, fin_valid}, 32'd1);
          check("b2b_features", {24'd0, features_top}, {24'd0, b2b_exp[f]});
        end else begin
          check("b2b_gap", {31'd0, fin_valid}, 32'd0);
        end
      end
    end
    tick();
    check("b2b_drained", {31'd0, fin_valid}, 32'd0);
`endif

    // Reset mid-frame with a full buffer pending
    fin_ready = 1'b0;
    beat(2'd3, 1'b0);
    beat(2'd3, 1'b0);
    beat(2'd3, 1'b0);
    beat(2'd3, 1'b1);
    check("prerst_valid", {31'd0, fin_valid}, 32'd1);
    check("prerst_features", {24'd0, features_top}, 32'hFF);
`ifdef FEATURE_LOADER_DBUF_EN
    beat(2'd1, 1'b0);
    beat(2'd2, 1'b0);
`else
    tick();
    tick();
`endif
    rst = 1'b1;
    #1;
    check("midrst_din_ready", {31'd0, din_ready}, 32'd1);
    check("midrst_fin_valid", {31'd0, fin_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_features", {24'd0, features_top}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_frame_err", {31'd0, frame_err}, 32'd0);
    tick();
    check("postrst_frame_err2", {31'd0, frame_err}, 32'd0);
    check("postrst_fin_valid", {31'd0, fin_valid}, 32'd0);
    fin_ready = 1'b1;
    beat(2'd0, 1'b0);
    beat(2'd0, 1'b0);
    beat(2'd0, 1'b0);
    beat(2'd1, 1'b1);
    check("postrst_valid", {31'd0, fin_valid}, 32'd1);
    check("postrst_features", {24'd0, features_top}, 32'h01);
    tick();
    check("postrst_consumed", {31'd0, fin_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
